// File: rtl/seqdiv.sv
// Restoring sequential divider: one quotient bit per clock using an A/Q/M register pair.
// Optional macro SEQDIV_DIVZERO_EN: divide-by-zero short-circuits the run and raises dz.
module seqdiv #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH-1:0]   q_q, q_d, m_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   quot_q, rem_q;
    logic [WIDTH+1:0]   sh_full;
    logic [WIDTH+1:0]   t;

    // A never exceeds M after an iteration, so its top bit is always zero here.
    always_comb begin
        sh_full = {a_q, q_q[WIDTH-1]};
        t       = sh_full - {2'b00, m_q};
        if (t[WIDTH+1]) begin
            a_d = sh_full[WIDTH:0];
            q_d = {q_q[WIDTH-2:0], 1'b0};
        end else begin
            a_d = t[WIDTH:0];
            q_d = {q_q[WIDTH-2:0], 1'b1};
        end
    end

`ifdef SEQDIV_DIVZERO_EN
    logic dz_q;
    assign dz = dz_q;
`else
    assign dz = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
`ifdef SEQDIV_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= '0;
                        q_q   <= dividend;
                        m_q   <= divisor;
                        cnt_q <= '0;
`ifdef SEQDIV_DIVZERO_EN
                        if (divisor == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            quot_q  <= '1;
                            rem_q   <= dividend;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end
`else
                        state_q <= RUN;
                        busy_q  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        quot_q  <= q_d;
                        rem_q   <= a_d[WIDTH-1:0];
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef SEQDIV_DIVZERO_EN
                        dz_q    <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: tb/tb_seqdiv.sv
// Directed bench for seqdiv (WIDTH=4): latency, handshake, reset abort, divide-by-zero, exhaustive invariant.
module tb_seqdiv;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dz;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_pass   = 0;

    seqdiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Start an op at the next edge k; return edges after k until done (0 = done at k).
    task automatic do_op(input int dd, input int dv, input bit chk_busy, output int lat);
        @(negedge clk);
        start    = 1'b1;
        dividend = dd[W-1:0];
        divisor  = dv[W-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 20) begin
            if (chk_busy) chk("busy_run", int'(busy), 1);
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_busy) chk("busy_at_done", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("done_pulse_end", int'(done), 0);
    endtask

    initial begin
        int lat;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dz", int'(dz), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem", int'(remainder), 0);
        @(negedge clk);
        reset = 1'b1;

        // 13/4
        do_op(13, 4, 1'b1, lat);
        chk("t1_lat", lat, 4);
        chk("t1_quot", int'(quotient), 3);
        chk("t1_rem", int'(remainder), 1);

        do_op(15, 1, 1'b1, lat);
        chk("t2a_quot", int'(quotient), 15);
        chk("t2a_rem", int'(remainder), 0);
        do_op(3, 7, 1'b1, lat);
        chk("t2b_quot", int'(quotient), 0);
        chk("t2b_rem", int'(remainder), 3);

        // divide by zero
`ifdef SEQDIV_DIVZERO_EN
        do_op(9, 0, 1'b0, lat);
        chk("t3_lat", lat, 0);
        chk("t3_dz", int'(dz), 1);
        chk("t3_busy", int'(busy), 0);
`else
        do_op(9, 0, 1'b1, lat);
        chk("t3_lat", lat, 4);
        chk("t3_dz", int'(dz), 0);
`endif
        chk("t3_quot", int'(quotient), 15);
        chk("t3_rem", int'(remainder), 9);
        do_op(8, 2, 1'b1, lat);
        chk("t3b_dz", int'(dz), 0);
        chk("t3b_quot", int'(quotient), 4);
        chk("t3b_rem", int'(remainder), 0);

        // start held high during RUN and DONE with new operands
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        dividend = 4'd6;
        divisor  = 4'd3;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4_lat", lat, 4);
        chk("t4_quot", int'(quotient), 3);
        chk("t4_rem", int'(remainder), 1);
        @(posedge clk);
        #1;
        chk("t4_done_ignored", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("t4_idle_accept", int'(busy), 1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("t4b_lat", lat, 4);
        chk("t4b_quot", int'(quotient), 2);
        chk("t4b_rem", int'(remainder), 0);
        @(posedge clk);
        #1;

        // async reset mid-run, then a clean op
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_quot", int'(quotient), 0);
        chk("t5_rem", int'(remainder), 0);
        lat = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) lat++;
        end
        chk("t5_no_done", lat, 0);
        @(negedge clk);
        reset = 1'b1;
        do_op(10, 3, 1'b1, lat);
        chk("t5b_quot", int'(quotient), 3);
        chk("t5b_rem", int'(remainder), 1);

        // exhaustive nonzero divisors
        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 1; dv < 16; dv++) begin
                do_op(dd, dv, 1'b0, lat);
                chk("ex_lat", lat, 4);
                chk("ex_inv", int'(quotient) * dv + int'(remainder), dd);
                chk("ex_rlt", int'(int'(remainder) < dv), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
